// File: rtl/soc_network_adapter_bb_responder.sv
// Target-side NoC DMA responder: parses read/write request packets, runs them as a bus master
// on local memory and returns one response packet per request. Optional: SOC_NA_RESPONDER_RANGE_CHECK_EN.
module soc_network_adapter_bb_responder #(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned TILEID     = 0,
    parameter logic [31:0] MEM_BASE   = 32'h0,
    parameter logic [31:0] MEM_SIZE   = 32'h10000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] noc_in_flit,
    input  logic                  noc_in_last,
    input  logic                  noc_in_valid,
    output logic                  noc_in_ready,
    output logic [FLIT_WIDTH-1:0] noc_out_flit,
    output logic                  noc_out_last,
    output logic                  noc_out_valid,
    input  logic                  noc_out_ready,
    output logic [AW-1:0]         bbm_addr_o,
    output logic [31:0]           bbm_din_o,
    output logic                  bbm_en_o,
    output logic                  bbm_we_o,
    input  logic [31:0]           bbm_dout_i
);

`ifdef SOC_NA_RESPONDER_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    localparam logic [4:0] TILE_ID = 5'(TILEID);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WRITE, S_RD_HDR, S_RD_REQ, S_RD_CAP, S_RD_SEND, S_DROP, S_ACK
    } state_t;

    state_t        state;
    logic [4:0]    req_src;
    logic [2:0]    req_cls;
    logic          req_rw;
    logic [7:0]    req_len;
    logic [7:0]    done;
    logic [AW-1:0] addr;
    logic          drop_err;

    logic          acc;
    logic [7:0]    done_nx;
    logic [AW-1:0] in_addr;
    logic [AW:0]   rc_start, rc_last, win_lo, win_hi;
    logic          addr_ok;

    function automatic logic [FLIT_WIDTH-1:0] rsp_hdr(input logic [4:0] dst, input logic [2:0] cls,
                                                      input logic rw, input logic err,
                                                      input logic [7:0] len);
        logic [FLIT_WIDTH-1:0] h;
        h        = '0;
        h[31:27] = dst;
        h[26:24] = cls;
        h[23:19] = TILE_ID;
        h[13]    = err;
        h[12]    = rw;
        h[7:0]   = len;
        return h;
    endfunction

    assign noc_in_ready = !rst && (state == S_IDLE || state == S_ADDR ||
                                   state == S_WRITE || state == S_DROP);
    assign acc     = noc_in_valid && noc_in_ready;
    assign done_nx = done + 8'd1;
    assign in_addr = {noc_in_flit[AW-1:2], 2'b00};

    // Window check is done one bit wider than the address so the end address cannot wrap.
    always_comb begin
        rc_start = {1'b0, in_addr};
        if (req_len != 8'd0)
            rc_last = rc_start + (AW+1)'({req_len, 2'b00}) - (AW+1)'(1);
        else
            rc_last = rc_start;
        win_lo  = (AW+1)'(MEM_BASE);
        win_hi  = win_lo + (AW+1)'(MEM_SIZE);
        addr_ok = !RANGE_CHECK || (rc_start >= win_lo && rc_last < win_hi);
    end

    always_comb begin
        bbm_en_o   = 1'b0;
        bbm_we_o   = 1'b0;
        bbm_din_o  = '0;
        bbm_addr_o = addr;
        if (state == S_WRITE && acc) begin
            bbm_en_o  = 1'b1;
            bbm_we_o  = 1'b1;
            bbm_din_o = noc_in_flit[31:0];
        end else if (state == S_RD_REQ) begin
            bbm_en_o = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            req_src       <= '0;
            req_cls       <= '0;
            req_rw        <= 1'b0;
            req_len       <= '0;
            done          <= '0;
            addr          <= '0;
            drop_err      <= 1'b0;
            noc_out_flit  <= '0;
            noc_out_valid <= 1'b0;
            noc_out_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (acc) begin
                    req_src  <= noc_in_flit[23:19];
                    req_cls  <= noc_in_flit[26:24];
                    req_rw   <= noc_in_flit[12];
                    req_len  <= noc_in_flit[7:0];
                    done     <= '0;
                    drop_err <= 1'b0;
                    if (noc_in_last) begin
                        noc_out_flit  <= rsp_hdr(noc_in_flit[23:19], noc_in_flit[26:24],
                                                 noc_in_flit[12], 1'b1, 8'd0);
                        noc_out_valid <= 1'b1;
                        noc_out_last  <= 1'b1;
                        state         <= S_ACK;
                    end else begin
                        state <= S_ADDR;
                    end
                end
                S_ADDR: if (acc) begin
                    addr <= in_addr;
                    if (!addr_ok) begin
                        drop_err <= 1'b1;
                        if (noc_in_last) begin
                            noc_out_flit  <= rsp_hdr(req_src, req_cls, req_rw, 1'b1, 8'd0);
                            noc_out_valid <= 1'b1;
                            noc_out_last  <= 1'b1;
                            state         <= S_ACK;
                        end else begin
                            state <= S_DROP;
                        end
                    end else if (req_rw && req_len != 8'd0) begin
                        state <= S_WRITE;
                    end else if (!noc_in_last) begin
                        state <= S_DROP;
                    end else begin
                        noc_out_flit  <= rsp_hdr(req_src, req_cls, req_rw, 1'b0,
                                                 req_rw ? 8'd0 : req_len);
                        noc_out_valid <= 1'b1;
                        noc_out_last  <= req_rw || (req_len == 8'd0);
                        state         <= req_rw ? S_ACK : S_RD_HDR;
                    end
                end
                S_WRITE: if (acc) begin
                    addr <= addr + AW'(4);
                    done <= done_nx;
                    if (noc_in_last) begin
                        noc_out_flit  <= rsp_hdr(req_src, req_cls, req_rw, 1'b0, done_nx);
                        noc_out_valid <= 1'b1;
                        noc_out_last  <= 1'b1;
                        state         <= S_ACK;
                    end else if (done_nx == req_len) begin
                        state <= S_DROP;
                    end
                end
                S_DROP: if (acc && noc_in_last) begin
                    noc_out_valid <= 1'b1;
                    if (drop_err) begin
                        noc_out_flit <= rsp_hdr(req_src, req_cls, req_rw, 1'b1, 8'd0);
                        noc_out_last <= 1'b1;
                        state        <= S_ACK;
                    end else if (req_rw) begin
                        noc_out_flit <= rsp_hdr(req_src, req_cls, req_rw, 1'b0, done);
                        noc_out_last <= 1'b1;
                        state        <= S_ACK;
                    end else begin
                        noc_out_flit <= rsp_hdr(req_src, req_cls, req_rw, 1'b0, req_len);
                        noc_out_last <= (req_len == 8'd0);
                        state        <= S_RD_HDR;
                    end
                end
                S_ACK: if (noc_out_ready) begin
                    noc_out_valid <= 1'b0;
                    noc_out_last  <= 1'b0;
                    state         <= S_IDLE;
                end
                S_RD_HDR: if (noc_out_ready) begin
                    noc_out_valid <= 1'b0;
                    noc_out_last  <= 1'b0;
                    state         <= (req_len == 8'd0) ? S_IDLE : S_RD_REQ;
                end
                S_RD_REQ: state <= S_RD_CAP;
                // Read data lands directly in the output register; RD_SEND just holds it.
                S_RD_CAP: begin
                    noc_out_flit  <= FLIT_WIDTH'(bbm_dout_i);
                    noc_out_valid <= 1'b1;
                    noc_out_last  <= (done_nx == req_len);
                    state         <= S_RD_SEND;
                end
                S_RD_SEND: if (noc_out_ready) begin
                    noc_out_valid <= 1'b0;
                    noc_out_last  <= 1'b0;
                    addr          <= addr + AW'(4);
                    done          <= done_nx;
                    state         <= (done_nx == req_len) ? S_IDLE : S_RD_REQ;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_network_adapter_bb_responder.sv
// Directed bench for soc_network_adapter_bb_responder: requester src 9, class 2, responder TILEID 3.
module tb_soc_network_adapter_bb_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] noc_in_flit = '0;
    logic        noc_in_last = 1'b0;
    logic        noc_in_valid = 1'b0;
    logic        noc_in_ready;
    logic [31:0] noc_out_flit;
    logic        noc_out_last;
    logic        noc_out_valid;
    logic        noc_out_ready = 1'b1;
    logic [31:0] bbm_addr_o;
    logic [31:0] bbm_din_o;
    logic        bbm_en_o;
    logic        bbm_we_o;
    logic [31:0] bbm_dout_i = '0;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    soc_network_adapter_bb_responder #(
        .FLIT_WIDTH(32),
        .AW(32),
        .TILEID(3),
        .MEM_BASE(32'h0),
        .MEM_SIZE(32'h1000)
    ) dut (
        .clk(clk), .rst(rst),
        .noc_in_flit(noc_in_flit), .noc_in_last(noc_in_last),
        .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready),
        .noc_out_flit(noc_out_flit), .noc_out_last(noc_out_last),
        .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
        .bbm_addr_o(bbm_addr_o), .bbm_din_o(bbm_din_o),
        .bbm_en_o(bbm_en_o), .bbm_we_o(bbm_we_o), .bbm_dout_i(bbm_dout_i)
    );

    always #5 clk = ~clk;

    // Memory model and bus access log
    logic [31:0] mem [0:1023];
    logic [31:0] log_addr[$];
    logic [31:0] log_din[$];
    logic        log_we[$];

    always @(posedge clk) begin
        if (!rst && bbm_en_o) begin
            log_addr.push_back(bbm_addr_o);
            log_din.push_back(bbm_din_o);
            log_we.push_back(bbm_we_o);
            if (bbm_we_o) mem[bbm_addr_o[11:2]] <= bbm_din_o;
            else          bbm_dout_i <= mem[bbm_addr_o[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] req(input logic rw, input logic [7:0] len);
        return {5'd3, 3'd2, 5'd9, 5'd0, 1'b0, rw, 4'd0, len};
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_din.delete();
        log_we.delete();
    endtask

    task automatic send_flit(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        noc_in_flit  = d;
        noc_in_last  = l;
        noc_in_valid = 1'b1;
        #1;
        while (!noc_in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("in_ready", 32'(noc_in_ready), 32'd1);
        @(posedge clk);
        #1;
        noc_in_valid = 1'b0;
        noc_in_last  = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        @(negedge clk);
        while (!noc_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid", 32'(noc_out_valid), 32'd1);
    endtask

    task automatic recv(output logic [31:0] d, output logic l, output int n);
        wait_out(n);
        d = noc_out_flit;
        l = noc_out_last;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] d;
    logic        l;
    int          n;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(noc_in_ready), 32'd0);
        chk("rst_out_valid", 32'(noc_out_valid), 32'd0);
        chk("rst_out_flit", noc_out_flit, 32'h0);
        chk("rst_bus_en", 32'(bbm_en_o), 32'd0);
        chk("rst_bus_addr", bbm_addr_o, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(noc_in_ready), 32'd1);

        // Single write
        clear_log();
        send_flit(req(1'b1, 8'd1), 1'b0);
        send_flit(32'h0000_0100, 1'b0);
        send_flit(32'hDEAD_BEEF, 1'b1);
        chk("wr1_ack_valid_next", 32'(noc_out_valid), 32'd1);
        recv(d, l, n);
        chk("wr1_ack_hdr", d, 32'h4A18_1001);
        chk("wr1_ack_last", 32'(l), 32'd1);
        chk("wr1_bus_cnt", 32'(log_addr.size()), 32'd1);
        chk("wr1_bus_addr", log_addr[0], 32'h0000_0100);
        chk("wr1_bus_din", log_din[0], 32'hDEAD_BEEF);
        chk("wr1_bus_we", 32'(log_we[0]), 32'd1);

        // Burst write of 0..3 at 0x200, then burst read back
        send_flit(req(1'b1, 8'd4), 1'b0);
        send_flit(32'h0000_0200, 1'b0);
        for (int i = 0; i < 4; i++) send_flit(32'(i), i == 3);
        recv(d, l, n);
        chk("wr4_ack_hdr", d, 32'h4A18_1004);
        clear_log();
        send_flit(req(1'b0, 8'd4), 1'b0);
        send_flit(32'h0000_0200, 1'b1);
        chk("rd4_hdr_valid_next", 32'(noc_out_valid), 32'd1);
        recv(d, l, n);
        chk("rd4_hdr", d, 32'h4A18_0004);
        chk("rd4_hdr_last", 32'(l), 32'd0);
        for (int i = 0; i < 4; i++) begin
            recv(d, l, n);
            chk("rd4_data", d, 32'(i));
            chk("rd4_last", 32'(l), 32'(i == 3));
            chk("rd4_latency", 32'(n), 32'd2);
        end
        chk("rd4_bus_cnt", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rd4_bus_addr", log_addr[i], 32'h200 + 32'(4 * i));
            chk("rd4_bus_we", 32'(log_we[i]), 32'd0);
        end

        // Short write: len 4, last on the second data flit
        clear_log();
        send_flit(req(1'b1, 8'd4), 1'b0);
        send_flit(32'h0000_0300, 1'b0);
        send_flit(32'hA0A0_A0A0, 1'b0);
        send_flit(32'hA1A1_A1A1, 1'b1);
        recv(d, l, n);
        chk("short_wr_ack", d, 32'h4A18_1002);
        chk("short_wr_last", 32'(l), 32'd1);
        chk("short_wr_bus_cnt", 32'(log_addr.size()), 32'd2);
        chk("short_wr_addr1", log_addr[1], 32'h0000_0304);

        // Over-long read: len 2 with three trailing flits
        clear_log();
        send_flit(req(1'b0, 8'd2), 1'b0);
        send_flit(32'h0000_0300, 1'b0);
        send_flit(32'h1111_1111, 1'b0);
        send_flit(32'h2222_2222, 1'b0);
        send_flit(32'h3333_3333, 1'b1);
        recv(d, l, n);
        chk("long_rd_hdr", d, 32'h4A18_0002);
        recv(d, l, n);
        chk("long_rd_d0", d, 32'hA0A0_A0A0);
        chk("long_rd_l0", 32'(l), 32'd0);
        recv(d, l, n);
        chk("long_rd_d1", d, 32'hA1A1_A1A1);
        chk("long_rd_l1", 32'(l), 32'd1);
        chk("long_rd_bus_cnt", 32'(log_addr.size()), 32'd2);

        // Header-only request
        clear_log();
        send_flit(req(1'b0, 8'd5), 1'b1);
        recv(d, l, n);
        chk("hdr_only_rsp", d, 32'h4A18_2000);
        chk("hdr_only_last", 32'(l), 32'd1);
        chk("hdr_only_bus_cnt", 32'(log_addr.size()), 32'd0);

        // Zero-length write
        send_flit(req(1'b1, 8'd0), 1'b0);
        send_flit(32'h0000_0400, 1'b1);
        recv(d, l, n);
        chk("wr0_ack", d, 32'h4A18_1000);
        chk("wr0_bus_cnt", 32'(log_addr.size()), 32'd0);

        // Backpressure on header and data
        clear_log();
        noc_out_ready = 1'b0;
        send_flit(req(1'b0, 8'd1), 1'b0);
        send_flit(32'h0000_0100, 1'b1);
        wait_out(n);
        repeat (10) @(negedge clk);
        chk("bp_hdr_valid", 32'(noc_out_valid), 32'd1);
        chk("bp_hdr_flit", noc_out_flit, 32'h4A18_0001);
        noc_out_ready = 1'b1;
        @(posedge clk);
        #1;
        noc_out_ready = 1'b0;
        wait_out(n);
        chk("bp_data_latency", 32'(n), 32'd2);
        repeat (10) @(negedge clk);
        chk("bp_data_valid", 32'(noc_out_valid), 32'd1);
        chk("bp_data_flit", noc_out_flit, 32'hDEAD_BEEF);
        chk("bp_data_last", 32'(noc_out_last), 32'd1);
        chk("bp_bus_cnt", 32'(log_addr.size()), 32'd1);
        noc_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_done_valid", 32'(noc_out_valid), 32'd0);

        // Reset in the middle of a burst read
        send_flit(req(1'b0, 8'd4), 1'b0);
        send_flit(32'h0000_0200, 1'b1);
        recv(d, l, n);
        recv(d, l, n);
        chk("mid_rst_d0", d, 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(noc_out_valid), 32'd0);
        chk("mid_rst_out_flit", noc_out_flit, 32'h0);
        chk("mid_rst_bus_en", 32'(bbm_en_o), 32'd0);
        chk("mid_rst_bus_addr", bbm_addr_o, 32'h0);
        chk("mid_rst_in_ready", 32'(noc_in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_release_ready", 32'(noc_in_ready), 32'd1);
        send_flit(req(1'b1, 8'd1), 1'b0);
        send_flit(32'h0000_0104, 1'b0);
        send_flit(32'hCAFE_F00D, 1'b1);
        recv(d, l, n);
        chk("after_rst_ack", d, 32'h4A18_1001);

`ifdef SOC_NA_RESPONDER_RANGE_CHECK_EN
        // Range check: read crossing the end of a 0x1000-byte window
        clear_log();
        send_flit(req(1'b0, 8'd2), 1'b0);
        send_flit(32'h0000_0FFC, 1'b1);
        recv(d, l, n);
        chk("range_rsp", d, 32'h4A18_2000);
        chk("range_last", 32'(l), 32'd1);
        repeat (4) @(negedge clk);
        chk("range_bus_cnt", 32'(log_addr.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
